maze_port_arbiter: RTL and testbench
====================================

Name: maze_port_arbiter

Overview:
Shares the single read port of the maze/intersection lookup memory between the pacman movement block and the four ghost controllers. Requesters post a tile address and receive a grant, then a tagged read-data pulse. Within a frame a ghost cannot starve pacman, and pacman cannot starve a ghost. A hold input lets the game sequencer freeze and drain lookups on win/lose/restart transitions.

Parameters:
N_REQ, 5, number of requesters; index 0 = pacman, 1..4 = ghosts
ADDR_W, 10, tile index width (row*COLS+col)
DATA_W, 4, lookup word width; intersection exits {up,down,left,right}
RD_LAT, 1, memory read latency in cycles (1..3)

Ports:
board_clk  in  1  system clock, 100 MHz
Reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester read request, level
addr  in  N_REQ*ADDR_W  flattened request addresses; slot i at [i*ADDR_W +: ADDR_W]
hold  in  1  stop issuing new grants; drain in-flight reads
gnt  out  N_REQ  one-hot grant pulse, one cycle
rvalid  out  N_REQ  one-hot read-data-valid pulse
rdata  out  DATA_W  read data, qualified by rvalid
mem_en  out  1  memory read enable
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en
halted  out  1  high when hold is active and the pipeline is empty

Behaviour:
- Reset: All outputs are 0. FSM = RUN. RR pointer = 0. In-flight tag pipeline is cleared; in-flight reads are discarded with no rvalid.
- Request handshake:
  - A requester raises req[i] and holds addr slot i stable until it sees gnt[i].
  - req[i] may stay high for back-to-back reads; each gnt consumes exactly one request.
  - If req[i] is dropped before grant, the request is withdrawn and no error is raised.
- Grant timing:
  - At most one grant per cycle, combinational on the registered pointer.
  - In the grant cycle: gnt[i]=1, mem_en=1, mem_addr=addr slot i. These are registered outputs and appear on the cycle after the req sample.
- Arbitration:
  - Round-robin, starting the search at the pointer.
  - After a grant to i, pointer = (i+1) mod N_REQ, with wrap from N_REQ-1 to 0.
  - No grant leaves the pointer unchanged.
- Read return:
  - The granted index is shifted through a tag pipeline of depth RD_LAT.
  - rvalid[tag]=1 and rdata=mem_rdata exactly RD_LAT cycles after mem_en. Requester-visible latency is gnt + RD_LAT.
  - The pipeline is fully pipelined; sustained throughput is 1 read/cycle.
- FSM:
  - RUN -> DRAIN when hold=1. In DRAIN no gnt is issued.
  - DRAIN -> HALTED when the tag pipeline is empty. halted=1 in HALTED.
  - HALTED -> RUN when hold=0. DRAIN -> RUN directly if hold drops before the pipeline empties.
  - Pending reqs remain pending across hold; the pointer is preserved.
- Simultaneous events: hold rising in the same cycle as a would-be grant suppresses that grant. A grant issued the cycle before hold still returns its rvalid.
- Boundaries:
  - All req=0: no mem_en.
  - Single requester continuously requesting: granted every cycle.
  - All N_REQ requesting: each granted once per N_REQ cycles.

Optional Feature:
PACMAN_PRIO_EN
- Defined:
  - req[0] wins whenever asserted, except immediately after a grant to index 0 if any ghost is requesting. At least one ghost grant then follows.
  - Ghosts are round-robin among indices 1..N_REQ-1 with a separate pointer.
  - Guarantees pacman at least 1 of every 2 slots under contention.
- Undefined: pure round-robin as above.

Decomposition:
- Package pacman_pkg:
  - N_GHOSTS=4
  - REQ_PACMAN=0, REQ_GHOST0..3=1..4
  - typedef exits_t (4-bit packed struct up/down/left/right)
  - TILE_ADDR_W
  - typedef arb_state_t {RUN, DRAIN, HALTED}
- Sub-module maze_rr_pick: combinational rotate-priority one-hot picker. Inputs are a request vector and a start pointer; outputs are a one-hot grant and its index. It is instantiated once, twice under PACMAN_PRIO_EN.

Test Plan:
- Reset mid-stream: RD_LAT=2, grant issued, Reset pulsed next cycle -> no rvalid ever appears; gnt/rvalid/mem_en/halted all 0; pointer 0.
- Single requester: req=5'b00001, addr0=10'h123 held for 4 cycles -> gnt[0] every cycle, mem_addr=0x123; rvalid[0] RD_LAT cycles after each grant, rdata=model word.
- Full contention: req=5'b11111 for 10 cycles, pointer 0 -> grant order 0,1,2,3,4,0,1,2,3,4; each rvalid tagged to the matching index.
- Wrap: pointer=4, req=5'b10001 -> gnt[4] then gnt[0], then pointer = 1.
- Hold drain: RD_LAT=3, all requesting, hold raised -> no further gnt; 3 trailing rvalids delivered; halted=1 on the following cycle. Hold dropped -> grant resumes at the preserved pointer.
- PACMAN_PRIO_EN: req=5'b11111 for 8 cycles -> grants 0,1,0,2,0,3,0,4.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and constants for the pacman maze logic.
//   N_GHOSTS      number of ghost controllers
//   REQ_*         requester slot numbers on the maze lookup port
//   TILE_ADDR_W   tile index width (row*COLS+col)
//   exits_t       one maze lookup word: open exits of a tile
//   arb_state_t   lookup port arbiter control states
package pacman_pkg;

  localparam int N_GHOSTS    = 4;
  localparam int REQ_PACMAN  = 0;
  localparam int REQ_GHOST0  = 1;
  localparam int REQ_GHOST1  = 2;
  localparam int REQ_GHOST2  = 3;
  localparam int REQ_GHOST3  = 4;
  localparam int TILE_ADDR_W = 10;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } exits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/maze_rr_pick.sv
// Combinational rotate-priority picker.
// Searches req starting at index 'start' upward with wrap and returns the
// first asserted request.
//   req       request vector
//   start     index where the search begins (must be < N)
//   pick      one-hot winner (all zero when nothing requests)
//   pick_idx  index of the winner
//   found     a winner exists
module maze_rr_pick
  import pacman_pkg::*;
#(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     pick,
  output logic [PTR_W-1:0] pick_idx,
  output logic             found
);

  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/maze_port_arbiter.sv
// Shares the maze lookup memory read port between pacman (slot 0) and the
// ghost controllers (slots 1..N_REQ-1). Grants are registered one-hot pulses
// that coincide with mem_en/mem_addr; the granted slot travels down a tag
// pipeline of depth RD_LAT so the read data comes back tagged via rvalid.
// A hold input stops new grants, lets in-flight reads drain, then reports
// halted.
//
// Build option: define PACMAN_PRIO_EN to give pacman priority (it wins
// unless it won the previous grant and a ghost is waiting); ghosts then
// rotate among themselves on their own pointer. Undefined: plain
// round-robin across all requesters.
//
// Ports:
//   board_clk, Reset    clock, asynchronous active-high reset
//   req, addr           per-slot level request and flattened tile address
//   hold                freeze and drain
//   gnt                 one-hot grant pulse
//   rvalid, rdata       one-hot tagged read return and its data
//   mem_en, mem_addr    memory read command
//   mem_rdata           memory data, RD_LAT cycles after mem_en
//   halted              hold active and nothing in flight
module maze_port_arbiter
  import pacman_pkg::*;
#(
  parameter int N_REQ  = N_GHOSTS + 1,
  parameter int ADDR_W = TILE_ADDR_W,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                    board_clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic                    hold,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    halted
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t state, state_nxt;

  logic [PTR_W-1:0]  ptr;
  logic [N_REQ-1:0]  rr_pick;
  logic [PTR_W-1:0]  rr_idx;
  logic              rr_found;
  logic [N_REQ-1:0]  win_vec;
  logic [PTR_W-1:0]  win_idx;
  logic              win_any;
  logic              issue;
  logic [ADDR_W-1:0] sel_addr;
  logic              drained;
  logic [N_REQ-1:0]  rtag_p [RD_LAT];

  maze_rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req      (req),
    .start    (ptr),
    .pick     (rr_pick),
    .pick_idx (rr_idx),
    .found    (rr_found)
  );

`ifdef PACMAN_PRIO_EN
  localparam int G_N    = N_REQ - 1;
  localparam int GPTR_W = (G_N > 1) ? $clog2(G_N) : 1;

  logic [GPTR_W-1:0] gptr;
  logic [GPTR_W-1:0] g_idx;
  logic [G_N-1:0]    g_pick;
  logic              g_found;
  logic              last_pac;

  maze_rr_pick #(.N(G_N), .PTR_W(GPTR_W)) u_ghost_pick (
    .req      (req[N_REQ-1:1]),
    .start    (gptr),
    .pick     (g_pick),
    .pick_idx (g_idx),
    .found    (g_found)
  );

  // Pacman yields exactly one slot after its own grant when a ghost waits.
  always_comb begin
    win_vec = '0;
    win_idx = '0;
    win_any = 1'b0;
    if (req[REQ_PACMAN] && !(last_pac && g_found)) begin
      win_vec[REQ_PACMAN] = 1'b1;
      win_idx             = PTR_W'(REQ_PACMAN);
      win_any             = 1'b1;
    end else if (g_found) begin
      win_vec = {g_pick, 1'b0};
      win_idx = PTR_W'(g_idx) + PTR_W'(REQ_GHOST0);
      win_any = 1'b1;
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      last_pac <= 1'b0;
      gptr     <= '0;
    end else if (issue) begin
      last_pac <= win_vec[REQ_PACMAN];
      if (!win_vec[REQ_PACMAN])
        gptr <= (g_idx == GPTR_W'(G_N - 1)) ? '0 : g_idx + 1'b1;
    end
  end
`else
  always_comb begin
    win_vec = rr_pick;
    win_idx = rr_idx;
    win_any = rr_found;
  end
`endif

  // Hold suppresses a grant in the very cycle it is first seen.
  assign issue = (state == RUN) && !hold && win_any;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win_vec[i]) sel_addr = sel_addr | addr[i*ADDR_W +: ADDR_W];
  end

  // grant stage: gnt, mem_en and mem_addr leave together
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      gnt      <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      ptr      <= '0;
    end else begin
      gnt    <= issue ? win_vec : '0;
      mem_en <= issue;
      if (issue) begin
        mem_addr <= sel_addr;
        ptr      <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // tag stages: the last stage lines up with mem_rdata
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      for (int s = 0; s < RD_LAT; s++) rtag_p[s] <= '0;
    end else begin
      rtag_p[0] <= gnt;
      for (int s = 1; s < RD_LAT; s++) rtag_p[s] <= rtag_p[s-1];
    end
  end

  assign rvalid = rtag_p[RD_LAT-1];
  assign rdata  = (|rvalid) ? mem_rdata : '0;

  // Nothing will remain in flight after this edge: the final stage only
  // holds a read being delivered right now.
  always_comb begin
    drained = (gnt == '0);
    for (int s = 0; s < RD_LAT - 1; s++)
      if (rtag_p[s] != '0) drained = 1'b0;
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hold) state_nxt = DRAIN;
      DRAIN:   if (!hold) state_nxt = RUN;
               else if (drained) state_nxt = HALTED;
      HALTED:  if (!hold) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_maze_port_arbiter.sv
module tb_maze_port_arbiter;
  import pacman_pkg::*;

  localparam int N_REQ  = 5;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 3;

  logic                    board_clk = 1'b0;
  logic                    Reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic                    hold;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    halted;

  always #5 board_clk = ~board_clk;

  maze_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .req       (req),
    .addr      (addr),
    .hold      (hold),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .halted    (halted)
  );

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
    int                due;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  logic [ADDR_W-1:0] slot_addr [N_REQ];

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return a[3:0] + a[7:4] + {2'b00, a[9:8]};
  endfunction

  // Memory model with RD_LAT cycles of read latency.
  logic              md_en   [RD_LAT];
  logic [ADDR_W-1:0] md_addr [RD_LAT];
  always @(posedge board_clk) begin
    md_en[0]   <= mem_en;
    md_addr[0] <= mem_addr;
    for (int s = 1; s < RD_LAT; s++) begin
      md_en[s]   <= md_en[s-1];
      md_addr[s] <= md_addr[s-1];
    end
  end
  assign mem_rdata = md_en[RD_LAT-1] ? word_of(md_addr[RD_LAT-1]) : '0;

  always @(posedge board_clk) cyc <= cyc + 1;

  // Read-return scoreboard.
  always @(negedge board_clk) begin
    if (!Reset) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        sb_t e;
        logic [N_REQ-1:0] ev;
        e = sb.pop_front();
        ev = '0;
        ev[e.idx] = 1'b1;
        checks++;
        if (rvalid !== ev || rdata !== e.data) begin
          errors++;
          $display("FAIL rvalid_return cyc %0d got rvalid %b rdata %h want rvalid %b rdata %h",
                   cyc, rvalid, rdata, ev, e.data);
        end
      end else if (rvalid !== '0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected cyc %0d got rvalid %b want 00000", cyc, rvalid);
      end
    end
  end

  function automatic void expect_read(input int idx);
    sb_t e;
    e.idx  = idx;
    e.data = word_of(slot_addr[idx]);
    e.due  = cyc + RD_LAT;
    sb.push_back(e);
  endfunction

  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    @(negedge board_clk) Reset = 1'b0;
    step();
    req = 5'b00001;
    step();
    checks++; if (gnt !== 5'b00001) begin errors++; $display("FAIL pre_reset_gnt got %b want 00001", gnt); end
    req = '0;
    #2 Reset = 1'b1;
    #1;
    checks++; if (gnt !== '0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL midreset_clear got gnt %b mem_en %b want 0 0", gnt, mem_en);
    end
    step();
    @(negedge board_clk) Reset = 1'b0;
    for (int n = 0; n < RD_LAT + 2; n++) begin
      step();
      checks++; if (rvalid !== '0) begin errors++; $display("FAIL discarded_read got rvalid %b want 0", rvalid); end
    end
    req = 5'b11111;
    step();
    checks++; if (gnt !== 5'b00001) begin errors++; $display("FAIL reset_ptr got %b want 00001", gnt); end
    expect_read(0);
    req = '0;
  endtask

  task automatic test_single();
    req = 5'b00001;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++; if (gnt !== 5'b00001) begin errors++; $display("FAIL single_gnt cycle %0d got %b want 00001", n, gnt); end
      checks++; if (mem_addr !== 10'h123) begin errors++; $display("FAIL single_addr got %h want 123", mem_addr); end
      expect_read(0);
    end
    req = '0;
    repeat (RD_LAT + 1) step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_drain got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_contention();
    logic [N_REQ-1:0] ev;
    req = 5'b10000;
    step();
    checks++; if (gnt !== 5'b10000) begin errors++; $display("FAIL cont_setup got %b want 10000", gnt); end
    expect_read(4);
    req = 5'b11111;
    for (int k = 0; k < 10; k++) begin
      step();
      ev = '0;
      ev[k % N_REQ] = 1'b1;
      checks++; if (gnt !== ev || mem_addr !== slot_addr[k % N_REQ]) begin
        errors++; $display("FAIL cont_order k %0d got %b/%h want %b/%h", k, gnt, mem_addr, ev, slot_addr[k % N_REQ]);
      end
      expect_read(k % N_REQ);
    end
    req = '0;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (mem_en !== 1'b0 || gnt !== '0) begin
        errors++; $display("FAIL idle_no_mem_en got mem_en %b gnt %b want 0 0", mem_en, gnt);
      end
    end
  endtask

  task automatic test_wrap();
    req = 5'b01000;
    step();
    checks++; if (gnt !== 5'b01000) begin errors++; $display("FAIL wrap_setup got %b want 01000", gnt); end
    expect_read(3);
    req = 5'b10001;
    step();
    checks++; if (gnt !== 5'b10000) begin errors++; $display("FAIL wrap_first got %b want 10000", gnt); end
    expect_read(4);
    step();
    checks++; if (gnt !== 5'b00001) begin errors++; $display("FAIL wrap_second got %b want 00001", gnt); end
    expect_read(0);
    req = 5'b00011;
    step();
    checks++; if (gnt !== 5'b00010) begin errors++; $display("FAIL wrap_ptr1 got %b want 00010", gnt); end
    expect_read(1);
    req = '0;
  endtask

  task automatic test_hold();
    int exp_seq [4] = '{2, 3, 4, 0};
    logic [N_REQ-1:0] ev;
    int n;
    req = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      step();
      ev = '0;
      ev[exp_seq[k]] = 1'b1;
      checks++; if (gnt !== ev) begin errors++; $display("FAIL hold_pre k %0d got %b want %b", k, gnt, ev); end
      expect_read(exp_seq[k]);
    end
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (gnt !== '0 || mem_en !== 1'b0 || halted !== 1'b0) begin
        errors++; $display("FAIL hold_drain k %0d got gnt %b mem_en %b halted %b want 0 0 0", k, gnt, mem_en, halted);
      end
    end
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hold_halted got %b want 1", halted); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL hold_trailing got %0d pending want 0", sb.size()); end
    step();
    checks++; if (halted !== 1'b1 || gnt !== '0) begin
      errors++; $display("FAIL hold_stay got halted %b gnt %b want 1 0", halted, gnt);
    end
    hold = 1'b0;
    n = 0;
    while (gnt === '0 && n < 4) begin
      step();
      n++;
    end
    checks++; if (gnt !== 5'b00010) begin errors++; $display("FAIL hold_resume got %b want 00010", gnt); end
    if (gnt !== '0) expect_read(1);
    step();
    checks++; if (gnt !== 5'b00100) begin errors++; $display("FAIL hold_resume_next got %b want 00100", gnt); end
    expect_read(2);
    req = '0;
  endtask

  task automatic test_pacman_prio();
    int exp_seq [8] = '{0, 1, 0, 2, 0, 3, 0, 4};
    logic [N_REQ-1:0] ev;
    repeat (RD_LAT + 2) step();
    @(negedge board_clk) Reset = 1'b1;
    step();
    @(negedge board_clk) Reset = 1'b0;
    sb.delete();
    req = 5'b11111;
    for (int k = 0; k < 8; k++) begin
      step();
      ev = '0;
      ev[exp_seq[k]] = 1'b1;
      checks++; if (gnt !== ev) begin errors++; $display("FAIL prio_order k %0d got %b want %b", k, gnt, ev); end
      expect_read(exp_seq[k]);
    end
    req = '0;
  endtask

  initial begin
    Reset = 1'b1;
    req   = '0;
    hold  = 1'b0;
    slot_addr[0] = 10'h123;
    slot_addr[1] = 10'h2A5;
    slot_addr[2] = 10'h0C7;
    slot_addr[3] = 10'h319;
    slot_addr[4] = 10'h1EB;
    for (int i = 0; i < N_REQ; i++) addr[i*ADDR_W +: ADDR_W] = slot_addr[i];

    test_reset();
    test_single();
`ifdef PACMAN_PRIO_EN
    test_pacman_prio();
`else
    test_contention();
    test_wrap();
    test_hold();
`endif
    repeat (RD_LAT + 2) step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d pending want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
